// File: rtl/fixedpoint_pkg.sv
// Shared definitions for the fixed-point accumulator: FSM encoding, default
// formats and saturation-limit helpers derived from the accumulator format.
package fixedpoint_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_WI    = 5;
  localparam int DEF_WF    = 6;
  localparam int DEF_WIA   = 8;
  localparam int DEF_LEN_W = 8;

  // Limits of a signed two's-complement word of w bits (w = WIA + WF).
  function automatic logic signed [63:0] sat_max(input int w);
    sat_max = (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    sat_min = -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fixedpoint_sat_adder.sv
// Signed adder with one guard bit and clamping to the W-bit signed range.
module fixedpoint_sat_adder
  import fixedpoint_pkg::*;
#(
  parameter int W = DEF_WIA + DEF_WF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                sat
);

  localparam logic signed [W:0] MAX_W = (W+1)'(sat_max(W));
  localparam logic signed [W:0] MIN_W = (W+1)'(sat_min(W));

  logic signed [W:0] full;

  function automatic logic signed [W-1:0] clamp(input logic signed [W:0] x);
    if (x > MAX_W)
      clamp = MAX_W[W-1:0];
    else if (x < MIN_W)
      clamp = MIN_W[W-1:0];
    else
      clamp = x[W-1:0];
  endfunction

  assign full = $signed({a[W-1], a}) + $signed({b[W-1], b});
  assign sum  = clamp(full);
  assign sat  = (full > MAX_W) || (full < MIN_W);

endmodule

// File: rtl/fixedpoint_accumulator.sv
// Sums a counted burst of signed products into a saturating accumulator and
// holds the result, with a sticky overflow flag, until downstream takes it.
module fixedpoint_accumulator
  import fixedpoint_pkg::*;
#(
  parameter int WI    = DEF_WI,
  parameter int WF    = DEF_WF,
  parameter int WIA   = DEF_WIA,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  input  logic signed [WI+WF-1:0]  in_data,
  input  logic                     in_ovf,
  output logic                     in_ready,
  output logic signed [WIA+WF-1:0] acc_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overFlow
);

  localparam int IW = WI + WF;
  localparam int AW = WIA + WF;

  state_t               state, state_nxt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] in_ext;
  logic signed [AW-1:0] sum;
  logic                 sat;
  logic [LEN_W-1:0]     count;
  logic                 ovf;
  logic                 beat;

  // Same fraction length on both sides, so only the integer part is extended.
  assign in_ext = {{(AW-IW){in_data[IW-1]}}, in_data};
  assign beat   = (state == ACCUM) && in_valid;

  fixedpoint_sat_adder #(.W(AW)) u_sat_adder (
    .a   (acc),
    .b   (in_ext),
    .sum (sum),
    .sat (sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? HOLD : ACCUM;
      ACCUM:   if (beat && count == LEN_W'(1)) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, beat counter and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      acc   <= '0;
      count <= len;
      ovf   <= 1'b0;
    end else if (beat) begin
      acc   <= sum;
      count <= count - LEN_W'(1);
      if (sat || in_ovf) ovf <= 1'b1;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign acc_out   = acc;
  assign overFlow  = ovf;

endmodule

// File: tb/tb_fixedpoint_accumulator.sv
// Directed bench for fixedpoint_accumulator with hand-computed expectations.
module tb_fixedpoint_accumulator;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [7:0]         len;
  logic               in_valid;
  logic signed [10:0] in_data;
  logic               in_ovf;
  logic               in_ready;
  logic signed [13:0] acc_out;
  logic               out_valid;
  logic               out_ready;
  logic               overFlow;

  int n_checks = 0;
  int n_err    = 0;

  fixedpoint_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ovf    (in_ovf),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overFlow  (overFlow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic signed [10:0] d, input logic o);
    in_valid = 1'b1;
    in_data  = d;
    in_ovf   = o;
    step();
    in_valid = 1'b0;
    in_ovf   = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; in_ovf = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_acc", acc_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_ovf", overFlow, 0);
    step(); step();
    reset = 1'b0;
    step();

    // Basic sum 1.0 + 2.0 - 0.5 + 0.25
    do_start(8'd4);
    check("t1_in_ready", in_ready, 1);
    beat(11'sd64, 1'b0);
    beat(11'sd128, 1'b0);
    beat(-11'sd32, 1'b0);
    check("t1_no_valid_early", out_valid, 0);
    beat(11'sd16, 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_acc", acc_out, 176);
    check("t1_ovf", overFlow, 0);
    check("t1_in_ready_hold", in_ready, 0);
    release_result();
    check("t1_idle", out_valid, 0);

    // Positive saturation
    do_start(8'd9);
    for (int i = 0; i < 9; i++) beat(11'sd1023, 1'b0);
    check("t2_pos_acc", acc_out, 8191);
    check("t2_pos_ovf", overFlow, 1);
    release_result();

    // Negative saturation
    do_start(8'd9);
    for (int i = 0; i < 9; i++) beat(-11'sd1024, 1'b0);
    check("t2_neg_acc", acc_out, -8192);
    check("t2_neg_ovf", overFlow, 1);
    release_result();

    // Upstream overflow is sticky, cleared by the next start
    do_start(8'd2);
    beat(11'sd5, 1'b1);
    beat(11'sd3, 1'b0);
    check("t3_acc", acc_out, 8);
    check("t3_ovf", overFlow, 1);
    release_result();
    do_start(8'd1);
    check("t3_ovf_cleared", overFlow, 0);
    beat(11'sd1, 1'b0);
    check("t3b_acc", acc_out, 1);

    // Held result ignores start and in_valid while out_ready is low
    start = 1'b1; len = 8'd3; in_valid = 1'b1; in_data = 11'sd100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_acc", acc_out, 1);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_ready", in_ready, 0);
    end
    start = 1'b0; in_valid = 1'b0;
    release_result();
    check("t4_idle", out_valid, 0);
    check("t4_idle_ready", in_ready, 0);

    // Asynchronous reset mid-accumulation
    do_start(8'd4);
    beat(11'sd64, 1'b0);
    beat(11'sd64, 1'b0);
    check("t5_partial", acc_out, 128);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_acc", acc_out, 0);
    check("t5_rst_ready", in_ready, 0);
    check("t5_rst_valid", out_valid, 0);
    step();
    reset = 1'b0;
    in_valid = 1'b1; in_data = 11'sd50;
    step(); step();
    in_valid = 1'b0;
    check("t5_no_beat_acc", acc_out, 0);
    check("t5_no_beat_ready", in_ready, 0);
    do_start(8'd1);
    beat(11'sd64, 1'b0);
    check("t5_acc", acc_out, 64);
    check("t5_valid", out_valid, 1);
    release_result();

    // Zero-length burst goes straight to HOLD with a cleared result
    in_valid = 1'b1; in_data = 11'sd7;
    do_start(8'd0);
    check("t6_valid", out_valid, 1);
    check("t6_acc", acc_out, 0);
    check("t6_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    check("t6_acc_stable", acc_out, 0);
    release_result();
    check("t6_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
